// File: rtl/bsg_cache_nb_tbuf_snoop_deep_if.sv
// Push/pop handshake bundle for the non-blocking cache tag buffer.
// The master side pushes {addr, way} and pops the head; the slave side is the buffer.
interface bsg_cache_nb_tbuf_snoop_deep_if
    #(parameter int addr_width_p   = 32
    , parameter int way_id_width_p = 3
    );

    logic                      v_i;
    logic [addr_width_p-1:0]   addr_i;
    logic [way_id_width_p-1:0] way_i;
    logic                      yumi_i;

    logic                      v_o;
    logic [addr_width_p-1:0]   addr_o;
    logic [way_id_width_p-1:0] way_o;

    modport master (output v_i, addr_i, way_i, yumi_i, input  v_o, addr_o, way_o);
    modport slave  (input  v_i, addr_i, way_i, yumi_i, output v_o, addr_o, way_o);

endinterface

// File: rtl/bsg_cache_nb_tbuf_snoop_deep.sv
// Circular tag buffer holding pending store {addr, way} pairs in FIFO order, with
// age-ordered snoop ports and a registered load-bypass hit/way lookup.
module bsg_cache_nb_tbuf_snoop_deep
    #(parameter int word_width_p          = 32
    , parameter int addr_width_p          = 32
    , parameter int ways_p                = 8
    , parameter int els_p                 = 4
    , parameter int block_size_in_words_p = 8
    , parameter int match_block_p         = 0
    , localparam int way_id_width_lp      = (ways_p > 1) ? $clog2(ways_p) : 1
    , localparam int count_width_lp       = $clog2(els_p + 1)
    )
    (input  logic                                 clk_i
    , input  logic                                reset_i

    , bsg_cache_nb_tbuf_snoop_deep_if.slave       bus

    , output logic                                empty_o
    , output logic                                full_o
    , output logic [count_width_lp-1:0]           count_o

    , input  logic                                bypass_v_i
    , input  logic [addr_width_p-1:0]             bypass_addr_i
    , output logic                                bypass_track_o
    , output logic [way_id_width_lp-1:0]          bypass_way_o

    , output logic [els_p-1:0]                    valid_snoop_o
    , output logic [els_p*addr_width_p-1:0]       addr_snoop_o
    , output logic [els_p*way_id_width_lp-1:0]    way_snoop_o
    );

    localparam int ptr_width_lp = $clog2(els_p);
    localparam int lg_word_lp   = $clog2(word_width_p / 8);
    localparam int off_lp       = lg_word_lp
                                + ((match_block_p != 0) ? $clog2(block_size_in_words_p) : 0);

    typedef logic [ptr_width_lp-1:0] ptr_t;

    logic [addr_width_p-1:0]    addr_mem_r [els_p];
    logic [way_id_width_lp-1:0] way_mem_r  [els_p];

    ptr_t                       rd_ptr_r;
    ptr_t                       wr_ptr_r;
    logic [count_width_lp-1:0]  count_r;
    logic                       track_r;
    logic [way_id_width_lp-1:0] track_way_r;

    logic                       push;
    logic                       pop;

    logic [addr_width_p-1:0]    slot_addr  [els_p];
    logic [way_id_width_lp-1:0] slot_way   [els_p];
    logic [els_p-1:0]           slot_valid;

    logic                       hit;
    logic [way_id_width_lp-1:0] hit_way;

    // Modular add that also works when els_p is not a power of two.
    function automatic ptr_t wrap_add(input ptr_t base, input int unsigned k);
        int unsigned sum;
        sum = 32'(base) + k;
        if (sum >= els_p)
            sum = sum - els_p;
        return ptr_t'(sum);
    endfunction

    assign push = bus.v_i;
    assign pop  = bus.yumi_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            track_r     <= 1'b0;
            track_way_r <= '0;
        end
        else begin
            if (push)
                wr_ptr_r <= wrap_add(wr_ptr_r, 1);
            if (pop)
                rd_ptr_r <= wrap_add(rd_ptr_r, 1);
            if (push && !pop)
                count_r <= count_r + 1'b1;
            else if (pop && !push)
                count_r <= count_r - 1'b1;
            if (bypass_v_i) begin
                track_r     <= hit;
                track_way_r <= hit_way;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            addr_mem_r[wr_ptr_r] <= bus.addr_i;
            way_mem_r[wr_ptr_r]  <= bus.way_i;
        end
    end

    always_comb begin
        ptr_t idx;
        for (int k = 0; k < els_p; k++) begin
            idx           = wrap_add(rd_ptr_r, unsigned'(k));
            slot_addr[k]  = addr_mem_r[idx];
            slot_way[k]   = way_mem_r[idx];
            slot_valid[k] = (count_width_lp'(k) < count_r);
        end
    end

    // Later (younger) matches override earlier ones; the incoming push is youngest of all.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int k = 0; k < els_p; k++) begin
            if (slot_valid[k] && ((slot_addr[k] >> off_lp) == (bypass_addr_i >> off_lp))) begin
                hit     = 1'b1;
                hit_way = slot_way[k];
            end
        end
        if (push && ((bus.addr_i >> off_lp) == (bypass_addr_i >> off_lp))) begin
            hit     = 1'b1;
            hit_way = bus.way_i;
        end
    end

    for (genvar k = 0; k < els_p; k++) begin : g_snoop
        assign addr_snoop_o[k*addr_width_p +: addr_width_p]       = slot_addr[k];
        assign way_snoop_o[k*way_id_width_lp +: way_id_width_lp]  = slot_way[k];
    end

    assign valid_snoop_o  = slot_valid;
    assign count_o        = count_r;
    assign empty_o        = (count_r == '0);
    assign full_o         = (count_r == count_width_lp'(els_p));
    assign bypass_track_o = track_r;
    assign bypass_way_o   = track_way_r;

    assign bus.v_o        = (count_r != '0);
    assign bus.addr_o     = addr_mem_r[rd_ptr_r];
    assign bus.way_o      = way_mem_r[rd_ptr_r];

    push_when_full_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.v_i && full_o && !bus.yumi_i));

    pop_when_empty_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.yumi_i && !bus.v_o));

endmodule

// File: tb/tb_bsg_cache_nb_tbuf_snoop_deep.sv
// Scoreboard bench for the tag buffer: dut 0 is els_p=4 word mode, dut 1 is els_p=3
// block mode (8 words x 4B); a queue model predicts head, snoop and bypass results.
module tb_bsg_cache_nb_tbuf_snoop_deep;

    typedef struct packed { logic [31:0] addr; logic [2:0] way; } entry_t;
    typedef struct packed { logic track; logic [2:0] way; } byp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        v_d   [2];
    logic [31:0] a_d   [2];
    logic [2:0]  w_d   [2];
    logic        y_d   [2];
    logic        bv_d  [2];
    logic [31:0] ba_d  [2];

    wire         vo    [2];
    wire  [31:0] ao    [2];
    wire  [2:0]  wo    [2];
    wire  [2:0]  cnt   [2];
    wire         emp   [2];
    wire         ful   [2];
    wire         trk   [2];
    wire  [2:0]  bw    [2];
    wire  [3:0]  vsn   [2];
    wire  [127:0] asn  [2];
    wire  [11:0] wsn   [2];

    wire  [1:0]  cnt_b;
    wire  [2:0]  vsn_b;
    wire  [95:0] asn_b;
    wire  [8:0]  wsn_b;

    entry_t mdl    [2][$];
    entry_t sb_pop [2][$];
    byp_t   sb_byp [2][$];
    byp_t   held   [2] = '{default: '0};
    logic   byp_pend [2] = '{1'b0, 1'b0};
    logic   armed    [2] = '{1'b0, 1'b0};

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    bsg_cache_nb_tbuf_snoop_deep_if #(.addr_width_p(32), .way_id_width_p(3)) bus_a ();
    bsg_cache_nb_tbuf_snoop_deep_if #(.addr_width_p(32), .way_id_width_p(3)) bus_b ();

    assign bus_a.v_i = v_d[0];  assign bus_a.addr_i = a_d[0];
    assign bus_a.way_i = w_d[0]; assign bus_a.yumi_i = y_d[0];
    assign bus_b.v_i = v_d[1];  assign bus_b.addr_i = a_d[1];
    assign bus_b.way_i = w_d[1]; assign bus_b.yumi_i = y_d[1];
    assign vo[0] = bus_a.v_o;  assign ao[0] = bus_a.addr_o;  assign wo[0] = bus_a.way_o;
    assign vo[1] = bus_b.v_o;  assign ao[1] = bus_b.addr_o;  assign wo[1] = bus_b.way_o;

    assign cnt[1] = {1'b0, cnt_b};
    assign vsn[1] = {1'b0, vsn_b};
    assign asn[1] = {32'h0, asn_b};
    assign wsn[1] = {3'h0, wsn_b};

    bsg_cache_nb_tbuf_snoop_deep #(.els_p(4), .match_block_p(0)) dut_a (
        .clk_i(clk), .reset_i(rst[0]), .bus(bus_a),
        .empty_o(emp[0]), .full_o(ful[0]), .count_o(cnt[0]),
        .bypass_v_i(bv_d[0]), .bypass_addr_i(ba_d[0]),
        .bypass_track_o(trk[0]), .bypass_way_o(bw[0]),
        .valid_snoop_o(vsn[0]), .addr_snoop_o(asn[0]), .way_snoop_o(wsn[0]));

    bsg_cache_nb_tbuf_snoop_deep #(.els_p(3), .match_block_p(1), .block_size_in_words_p(8)) dut_b (
        .clk_i(clk), .reset_i(rst[1]), .bus(bus_b),
        .empty_o(emp[1]), .full_o(ful[1]), .count_o(cnt_b),
        .bypass_v_i(bv_d[1]), .bypass_addr_i(ba_d[1]),
        .bypass_track_o(trk[1]), .bypass_way_o(bw[1]),
        .valid_snoop_o(vsn_b), .addr_snoop_o(asn_b), .way_snoop_o(wsn_b));

    function automatic int els_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int off_of(input int d);
        return (d == 0) ? 2 : 5;
    endfunction

    task automatic checkOutput(input int d, input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL dut%0d %s: actual=%h required=%h (t=%0t)", d, name, act, exp, $time);
        end
    endtask

    task automatic reportMissing(input int d, input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL dut%0d %s: actual=none required=queued entry (t=%0t)", d, name, $time);
    endtask

    // Reference lookup: walk the pending queue oldest to youngest, then the incoming push.
    function automatic byp_t modelBypass(input int d, input logic v, input logic [31:0] a,
                                         input logic [2:0] w, input logic [31:0] ba);
        byp_t r = '0;
        for (int i = 0; i < mdl[d].size(); i++)
            if ((mdl[d][i].addr >> off_of(d)) == (ba >> off_of(d))) begin
                r.track = 1'b1;
                r.way   = mdl[d][i].way;
            end
        if (v && ((a >> off_of(d)) == (ba >> off_of(d)))) begin
            r.track = 1'b1;
            r.way   = w;
        end
        return r;
    endfunction

    task automatic applyStimulus(input int d, input logic v, input logic [31:0] a,
                                 input logic [2:0] w, input logic y,
                                 input logic bv, input logic [31:0] ba);
        entry_t e;
        e.addr = a;
        e.way  = w;
        v_d[d] = v; a_d[d] = a; w_d[d] = w; y_d[d] = y; bv_d[d] = bv; ba_d[d] = ba;
        if (v)
            sb_pop[d].push_back(e);
        if (bv)
            sb_byp[d].push_back(modelBypass(d, v, a, w, ba));
        @(posedge clk);
        #1;
        if (y && mdl[d].size() > 0)
            void'(mdl[d].pop_front());
        if (v)
            mdl[d].push_back(e);
        v_d[d] = 1'b0; y_d[d] = 1'b0; bv_d[d] = 1'b0;
    endtask

    task automatic pulseReset(input int d, input bit traffic);
        rst[d] = 1'b1;
        if (traffic) begin
            v_d[d]  = 1'($urandom_range(0, 1));
            a_d[d]  = 32'h1000 + $urandom_range(0, 255);
            w_d[d]  = 3'($urandom_range(0, 7));
            y_d[d]  = (mdl[d].size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bv_d[d] = 1'($urandom_range(0, 1));
            ba_d[d] = 32'h1000 + $urandom_range(0, 255);
        end
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
        v_d[d] = 1'b0; y_d[d] = 1'b0; bv_d[d] = 1'b0;
        mdl[d].delete();
        sb_pop[d].delete();
        sb_byp[d].delete();
        checkOutput(d, "count_after_reset", 32'(cnt[d]), 0);
    endtask

    task automatic randomCycle(input int d);
        int   sz;
        logic y, v;
        sz = mdl[d].size();
        y  = (sz > 0) && ($urandom_range(0, 2) != 0);
        v  = ($urandom_range(0, 2) != 0) && ((sz < els_of(d)) || y);
        applyStimulus(d, v, 32'h1000 + $urandom_range(0, (8 << off_of(d)) - 1),
                      3'($urandom_range(0, 7)), y, 1'($urandom_range(0, 1)),
                      32'h1000 + $urandom_range(0, (8 << off_of(d)) - 1));
    endtask

    // Monitor: registered outputs are compared mid-cycle against the model and scoreboards.
    always @(negedge clk) begin
        entry_t me;
        for (int d = 0; d < 2; d++) begin
            if (armed[d]) begin
                if (!rst[d] && y_d[d] && vo[d]) begin
                    if (sb_pop[d].size() == 0)
                        reportMissing(d, "pop_scoreboard");
                    else begin
                        me = sb_pop[d].pop_front();
                        checkOutput(d, "pop_addr", ao[d], me.addr);
                        checkOutput(d, "pop_way", 32'(wo[d]), 32'(me.way));
                    end
                end
                if (byp_pend[d]) begin
                    if (sb_byp[d].size() == 0)
                        reportMissing(d, "bypass_scoreboard");
                    else
                        held[d] = sb_byp[d].pop_front();
                end
                checkOutput(d, "bypass_track", 32'(trk[d]), 32'(held[d].track));
                checkOutput(d, "bypass_way", 32'(bw[d]), 32'(held[d].way));
                checkOutput(d, "count", 32'(cnt[d]), mdl[d].size());
                checkOutput(d, "empty", 32'(emp[d]), 32'(mdl[d].size() == 0));
                checkOutput(d, "full", 32'(ful[d]), 32'(mdl[d].size() == els_of(d)));
                checkOutput(d, "v_o", 32'(vo[d]), 32'(mdl[d].size() != 0));
                if (mdl[d].size() != 0) begin
                    checkOutput(d, "head_addr", ao[d], mdl[d][0].addr);
                    checkOutput(d, "head_way", 32'(wo[d]), 32'(mdl[d][0].way));
                end
                for (int k = 0; k < els_of(d); k++) begin
                    checkOutput(d, "valid_snoop", 32'(vsn[d][k]), 32'(k < mdl[d].size()));
                    if (k < mdl[d].size()) begin
                        checkOutput(d, "snoop_addr", asn[d][k*32 +: 32], mdl[d][k].addr);
                        checkOutput(d, "snoop_way", 32'(wsn[d][k*3 +: 3]), 32'(mdl[d][k].way));
                    end
                end
                if (rst[d]) begin
                    held[d]     = '0;
                    byp_pend[d] = 1'b0;
                end
                else
                    byp_pend[d] = bv_d[d];
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; v_d[d] = 1'b0; a_d[d] = '0; w_d[d] = '0;
            y_d[d] = 1'b0; bv_d[d] = 1'b0; ba_d[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        armed[0] = 1'b1;
        armed[1] = 1'b1;
        checkOutput(0, "reset_count", 32'(cnt[0]), 0);
        checkOutput(0, "reset_track", 32'(trk[0]), 0);
        checkOutput(1, "reset_empty", 32'(emp[1]), 1);

        // two pushes, head and slot 1
        applyStimulus(0, 1'b1, 32'h100, 3'd1, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h104, 3'd2, 1'b0, 1'b0, 32'h0);
        checkOutput(0, "t1_count", 32'(cnt[0]), 2);
        checkOutput(0, "t1_addr_o", ao[0], 32'h100);
        checkOutput(0, "t1_slot1_addr", asn[0][63:32], 32'h104);
        checkOutput(0, "t1_slot1_way", 32'(wsn[0][5:3]), 2);
        checkOutput(0, "t1_valid_snoop", 32'(vsn[0]), 32'b0011);

        // fill, then push+pop while full so the pointers wrap
        applyStimulus(0, 1'b1, 32'h108, 3'd3, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h10C, 3'd4, 1'b0, 1'b0, 32'h0);
        checkOutput(0, "t2_full", 32'(ful[0]), 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b1, 32'h300 + 32'(i * 4), 3'(i), 1'b1, 1'b0, 32'h0);
            checkOutput(0, "t2_full_hold", 32'(ful[0]), 1);
        end
        repeat (4) applyStimulus(0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);
        checkOutput(0, "t2_drained", 32'(emp[0]), 1);

        // word-mode bypass: youngest of two matches wins
        applyStimulus(0, 1'b1, 32'h200, 3'd3, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h200, 3'd5, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h202);
        checkOutput(0, "t3_track_hit", 32'(trk[0]), 1);
        checkOutput(0, "t3_way_hit", 32'(bw[0]), 5);
        applyStimulus(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h204);
        checkOutput(0, "t3_track_miss", 32'(trk[0]), 0);
        checkOutput(0, "t3_way_miss", 32'(bw[0]), 0);
        repeat (2) applyStimulus(0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);

        // same-cycle push and bypass on an empty buffer, then hold
        applyStimulus(0, 1'b1, 32'h40, 3'd7, 1'b0, 1'b1, 32'h40);
        checkOutput(0, "t5_track", 32'(trk[0]), 1);
        checkOutput(0, "t5_way", 32'(bw[0]), 7);
        repeat (3) applyStimulus(0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0);
        checkOutput(0, "t5_track_held", 32'(trk[0]), 1);
        checkOutput(0, "t5_way_held", 32'(bw[0]), 7);
        applyStimulus(0, 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);

        // block-mode bypass
        applyStimulus(1, 1'b1, 32'h1000, 3'd6, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h101C);
        checkOutput(1, "t4_track_hit", 32'(trk[1]), 1);
        checkOutput(1, "t4_way_hit", 32'(bw[1]), 6);
        applyStimulus(1, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 32'h1020);
        checkOutput(1, "t4_track_miss", 32'(trk[1]), 0);

        // randomized traffic with occasional reset mid-stream
        for (int d = 1; d >= 0; d--) begin
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 39) == 0)
                    pulseReset(d, 1'b1);
                else
                    randomCycle(d);
            end
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
